// File: rtl/rv32_multicycle_ctrl_if.sv
// rv32_multicycle_ctrl_if: memory handshake and datapath strobes of the multi-cycle control sequencer.
interface rv32_multicycle_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] pc_target;
    logic        rf_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        halted;
    logic [1:0]  err_code;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, inst, pc, rf_we, dmem_req, dmem_we, halted, err_code,
        input  imem_ready, imem_rdata, branch_taken, pc_target, dmem_ready
    );

    // Memory / datapath side
    modport slave (
        input  imem_req, imem_addr, inst, pc, rf_we, dmem_req, dmem_we, halted, err_code,
        output imem_ready, imem_rdata, branch_taken, pc_target, dmem_ready
    );
endinterface

// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl: RV32I multi-cycle sequencer (FETCH/WAIT_I/DECODE/EXEC/MEM/WB/HALT).
// Optional macro RV32_CTRL_PERF_EN adds cycle_cnt / retire_cnt performance counters.
module rv32_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic clk,
    input  logic rst_n,
`ifdef RV32_CTRL_PERF_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt,
`endif
    rv32_multicycle_ctrl_if.master bus
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TMO_W = 8;
    localparam int unsigned OP_W  = 7;

    localparam logic [XLEN-1:0]  NOP_INST = 32'h0000_0013;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT_I,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  inst_q, inst_d;
    logic [XLEN-1:0]  tgt_q, tgt_d;
    logic             br_taken_q, br_taken_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       err_q, err_d;

    logic imem_req_q, imem_req_d;
    logic dmem_req_q, dmem_req_d;
    logic dmem_we_q, dmem_we_d;
    logic rf_we_q, rf_we_d;
    logic halted_q, halted_d;

    logic [OP_W-1:0] opcode;
    logic            op_legal;
    logic            is_load, is_store, is_branch, is_jump, is_system;
    logic            redirect;

    assign opcode    = inst_q[OP_W-1:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_system = (opcode == OP_SYSTEM);
    assign redirect  = is_jump || (is_branch && br_taken_q);

    // Opcode legality for the held instruction
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    // Next-state, datapath-register and strobe computation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        tgt_d      = tgt_q;
        br_taken_d = br_taken_q;
        tmo_d      = tmo_q;
        err_d      = err_q;

        case (state_q)
            S_FETCH: begin
                state_d = S_WAIT_I;
                tmo_d   = '0;
            end
            S_WAIT_I: begin
                if (bus.imem_ready) begin
                    inst_d  = bus.imem_rdata;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_HALT;
                    err_d   = 2'b10;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (!op_legal) begin
                    state_d = S_HALT;
                    err_d   = 2'b01;
                end else if (is_system) begin
                    state_d = S_HALT;
                    err_d   = 2'b11;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                br_taken_d = bus.branch_taken;
                tgt_d      = bus.pc_target;
                if (is_load || is_store) begin
                    state_d = S_MEM;
                    tmo_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    state_d = S_WB;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_HALT;
                    err_d   = 2'b10;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WB: begin
                // Targets are forced word-aligned
                pc_d    = redirect ? (tgt_q & ~XLEN'(3)) : (pc_q + XLEN'(4));
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        imem_req_d = (state_d == S_FETCH) || (state_d == S_WAIT_I);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) && is_store;
        rf_we_d    = (state_d == S_WB) && !is_store && !is_branch && (inst_q[11:7] != 5'd0);
        halted_d   = (state_d == S_HALT);
    end

    // State, datapath registers and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            tgt_q      <= '0;
            br_taken_q <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 2'b00;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            tgt_q      <= tgt_d;
            br_taken_q <= br_taken_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc_q;
    assign bus.inst      = inst_q;
    assign bus.pc        = pc_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.halted    = halted_q;
    assign bus.err_code  = err_q;

`ifdef RV32_CTRL_PERF_EN
    // Active-cycle and retired-instruction counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state_q != S_HALT) cycle_cnt <= cycle_cnt + XLEN'(1);
            if (state_q == S_WB)   retire_cnt <= retire_cnt + XLEN'(1);
        end
    end
`endif

endmodule
